// File: rtl/dram_model.sv
// -----------------------------------------------------------------------------
// dram_model
//
// Single-bank SDRAM device model driven from the far end of the DRAM pins.
// Decodes ACT / PRE / READ / byte-masked WRITE, enforces tRCD, tCL and tRP,
// keeps a 2^(ROW_BITS+COL_BITS) x 32-bit word array, and returns read data
// with a one-cycle valid pulse T_CL edges after the READ.
//
// Ports:
//   clk         rising-edge clock, all command sampling happens here
//   rst         asynchronous active-low reset
//   DRAM_CSn    chip select (active low); high means NOP
//   DRAM_RASn   row strobe (active low)
//   DRAM_CASn   column strobe (active low)
//   DRAM_WEn    per-byte write enable (active low), bit i -> D[8i+7:8i]
//   DRAM_A      row address on ACT, column address on READ/WRITE
//   DRAM_D      write data
//   DRAM_Q      registered read data, holds the last delivered word
//   DRAM_valid  registered one-cycle pulse qualifying DRAM_Q
//   err         sticky protocol-violation flag, cleared only by reset
//   state_dbg   current bank state (0 IDLE, 1 ACTIVATING, 2 ACTIVE,
//               3 PRECHARGING)
// -----------------------------------------------------------------------------
module dram_model #(
    parameter int ROW_BITS = 8,
    parameter int COL_BITS = 8,
    parameter int T_RCD    = 5,
    parameter int T_CL     = 5,
    parameter int T_RP     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DRAM_CSn,
    input  logic        DRAM_RASn,
    input  logic        DRAM_CASn,
    input  logic [3:0]  DRAM_WEn,
    input  logic [10:0] DRAM_A,
    input  logic [31:0] DRAM_D,
    output logic [31:0] DRAM_Q,
    output logic        DRAM_valid,
    output logic        err,
    output logic [1:0]  state_dbg
);

    localparam int AW = ROW_BITS + COL_BITS;
    // Timers count down to zero; the edge on which the timer already reads
    // zero is the first edge on which the next command is legal.
    localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);
    localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ACTIVATING  = 2'd1,
        S_ACTIVE      = 2'd2,
        S_PRECHARGING = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [3:0]            timer, timer_next;
    logic [ROW_BITS-1:0]   row;
    logic [31:0]           mem [0:(1<<AW)-1];
    logic [T_CL-1:0]       pv;
    logic [31:0]           pd [T_CL];

    logic cmd_act, cmd_pre, cmd_rd, cmd_wr, cmd_bad;
    logic eff_idle, eff_active;
    logic viol, do_act, do_read, do_write;
    logic [AW-1:0] addr;

    // Upper address bits beyond ROW_BITS/COL_BITS are intentionally ignored.
    logic unused_a;
    assign unused_a = ^DRAM_A;

    assign cmd_act = !DRAM_CSn && !DRAM_RASn &&  DRAM_CASn && (DRAM_WEn == 4'hf);
    assign cmd_pre = !DRAM_CSn && !DRAM_RASn &&  DRAM_CASn && (DRAM_WEn != 4'hf);
    assign cmd_rd  = !DRAM_CSn &&  DRAM_RASn && !DRAM_CASn && (DRAM_WEn == 4'hf);
    assign cmd_wr  = !DRAM_CSn &&  DRAM_RASn && !DRAM_CASn && (DRAM_WEn != 4'hf);
    assign cmd_bad = !DRAM_CSn && !DRAM_RASn && !DRAM_CASn;

    // A state whose timer has expired behaves as its successor on this edge,
    // which is what makes T_RCD=1 / T_RP=1 allow a command on the next edge.
    assign eff_idle   = (state == S_IDLE)   || (state == S_PRECHARGING && timer == 4'd0);
    assign eff_active = (state == S_ACTIVE) || (state == S_ACTIVATING  && timer == 4'd0);

    assign addr      = {row, DRAM_A[COL_BITS-1:0]};
    assign state_dbg = state;

    // Next-state / command acceptance
    always_comb begin
        state_next = state;
        timer_next = timer;
        viol       = 1'b0;
        do_act     = 1'b0;
        do_read    = 1'b0;
        do_write   = 1'b0;

        // Timed states advance on their own, even when a command is rejected.
        case (state)
            S_ACTIVATING: begin
                if (timer == 4'd0) state_next = S_ACTIVE;
                else               timer_next = timer - 4'd1;
            end
            S_PRECHARGING: begin
                if (timer == 4'd0) state_next = S_IDLE;
                else               timer_next = timer - 4'd1;
            end
            default: ;
        endcase

        if (cmd_bad) begin
            viol = 1'b1;
        end else if (cmd_act) begin
            if (eff_idle) begin
                do_act     = 1'b1;
                state_next = S_ACTIVATING;
                timer_next = RCD_LOAD;
            end else begin
                viol = 1'b1;
            end
        end else if (cmd_pre) begin
            if (eff_active) begin
                state_next = S_PRECHARGING;
                timer_next = RP_LOAD;
            end else if (state == S_ACTIVATING) begin
                viol = 1'b1;
            end
            // PRE while idle or already precharging is a harmless no-op.
        end else if (cmd_rd) begin
            if (eff_active) do_read = 1'b1;
            else            viol    = 1'b1;
        end else if (cmd_wr) begin
            if (eff_active) do_write = 1'b1;
            else            viol     = 1'b1;
        end
    end

    // State, row latch, error flag and read delay line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            timer      <= 4'd0;
            row        <= '0;
            err        <= 1'b0;
            pv         <= '0;
            DRAM_Q     <= 32'd0;
            DRAM_valid <= 1'b0;
            for (int i = 0; i < T_CL; i++) pd[i] <= 32'd0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (do_act) row <= DRAM_A[ROW_BITS-1:0];
            if (viol)   err <= 1'b1;

            // Data is captured at command time so later PRE/WRITE cannot
            // disturb reads already in flight.
            pv[0] <= do_read;
            pd[0] <= mem[addr];
            for (int i = T_CL - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end

            DRAM_valid <= pv[T_CL-1];
            if (pv[T_CL-1]) DRAM_Q <= pd[T_CL-1];
        end
    end

    // Word array: not reset, so contents persist across reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (!DRAM_WEn[b]) mem[addr][8*b +: 8] <= DRAM_D[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dram_model.sv
// -----------------------------------------------------------------------------
// tb_dram_model: directed, self-checking bench for dram_model with default
// parameters (ROW_BITS=8, COL_BITS=8, T_RCD=T_CL=T_RP=5). Inputs are driven
// 1 time unit after a rising edge and outputs are sampled at the same point,
// so each tick() call corresponds to exactly one sampling edge.
// -----------------------------------------------------------------------------
module tb_dram_model;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csn = 1'b1;
  logic        rasn = 1'b1;
  logic        casn = 1'b1;
  logic [3:0]  wen = 4'hf;
  logic [10:0] a = '0;
  logic [31:0] d = '0;
  logic [31:0] q;
  logic        valid;
  logic        err;
  logic [1:0]  st;

  int errors = 0;
  int checks = 0;

  dram_model dut (
    .clk        (clk),
    .rst        (rst),
    .DRAM_CSn   (csn),
    .DRAM_RASn  (rasn),
    .DRAM_CASn  (casn),
    .DRAM_WEn   (wen),
    .DRAM_A     (a),
    .DRAM_D     (d),
    .DRAM_Q     (q),
    .DRAM_valid (valid),
    .err        (err),
    .state_dbg  (st)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic c, input logic r, input logic ca,
                       input logic [3:0] w, input logic [10:0] aa,
                       input logic [31:0] dd);
    csn = c; rasn = r; casn = ca; wen = w; a = aa; d = dd;
    tick();
    csn = 1'b1; rasn = 1'b1; casn = 1'b1; wen = 4'hf; a = '0; d = '0;
  endtask

  task automatic act(input logic [10:0] r);
    drive(1'b0, 1'b0, 1'b1, 4'hf, r, 32'd0);
  endtask

  task automatic pre();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 11'd0, 32'd0);
  endtask

  task automatic rd(input logic [10:0] c);
    drive(1'b0, 1'b1, 1'b0, 4'hf, c, 32'd0);
  endtask

  task automatic wr(input logic [10:0] c, input logic [3:0] w, input logic [31:0] dd);
    drive(1'b0, 1'b1, 1'b0, w, c, dd);
  endtask

  task automatic bad();
    drive(1'b0, 1'b0, 1'b0, 4'hf, 11'd0, 32'd0);
  endtask

  // tests
  task automatic test_reset();
    nop(2);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
    rst = 1'b1;
    tick();
    bad();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_strobe_err: got %b want 1", err); end
    rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_reset_err: got %b want 0", err); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    act(11'd3);
    nop(4);
    wr(11'd7, 4'h0, 32'hDEADBEEF);
    rd(11'd7);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (valid !== 1'(k == 5)) begin errors++; $display("FAIL wr_rd_valid[%0d]: got %b want %b", k, valid, k == 5); end
      if (k == 5) begin
        checks++;
        if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_q: got %h want deadbeef", q); end
      end
    end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL q_hold: got %h want deadbeef", q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b want 0", err); end
    checks++; if (st !== 2'd2) begin errors++; $display("FAIL wr_rd_state: got %0d want 2", st); end
  endtask

  task automatic test_byte_mask();
    wr(11'd7, 4'b1010, 32'h11223344);
    rd(11'd7);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (valid !== 1'(k == 5)) begin errors++; $display("FAIL mask_valid[%0d]: got %b want %b", k, valid, k == 5); end
      if (k == 5) begin
        checks++;
        if (q !== 32'hDE22BE44) begin errors++; $display("FAIL mask_q: got %h want de22be44", q); end
      end
    end
  endtask

  task automatic test_trcd_violation();
    logic saw;
    saw = 1'b0;
    pre();
    nop(4);
    act(11'd4);
    nop(1);
    rd(11'd7);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL trcd_err: got %b want 1", err); end
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL trcd_state_activating: got %0d want 1", st); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (valid === 1'b1) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL trcd_no_pulse: got %b want 0", saw); end
    checks++; if (st !== 2'd2) begin errors++; $display("FAIL trcd_state_active: got %0d want 2", st); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL trcd_err_cleared: got %b want 0", err); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL trcd_state_idle: got %0d want 0", st); end
  endtask

  task automatic test_precharge_reopen();
    act(11'd3);
    nop(4);
    pre();
    nop(1);
    act(11'd5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL trp_err: got %b want 1", err); end
    checks++; if (st !== 2'd3) begin errors++; $display("FAIL trp_state: got %0d want 3", st); end
    nop(2);
    // Row bits above ROW_BITS are ignored: 11'h703 opens row 3.
    act(11'h703);
    checks++; if (st !== 2'd1) begin errors++; $display("FAIL reopen_state: got %0d want 1", st); end
    nop(4);
    rd(11'd7);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (valid !== 1'(k == 5)) begin errors++; $display("FAIL reopen_valid[%0d]: got %b want %b", k, valid, k == 5); end
      if (k == 5) begin
        checks++;
        if (q !== 32'hDE22BE44) begin errors++; $display("FAIL reopen_q: got %h want de22be44", q); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic        saw;
    wr(11'd8, 4'h0, 32'hCAFEF00D);
    wr(11'd9, 4'h0, 32'h12345678);
    exp_q.push_back(32'hDE22BE44);
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'h12345678);
    rd(11'd7);
    rd(11'h708); // column wraps to 8
    rd(11'd9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (valid !== 1'(k >= 3 && k <= 5)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, valid, k >= 3 && k <= 5); end
      if (k >= 3 && k <= 5 && exp_q.size() > 0) begin
        checks++;
        if (q !== exp_q[0]) begin errors++; $display("FAIL b2b_q[%0d]: got %h want %h", k, q, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end

    // Mid-flight reset discards all three reads.
    saw = 1'b0;
    rd(11'd7);
    rd(11'd8);
    rd(11'd9);
    rst = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (valid === 1'b1) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse: got %b want 0", saw); end
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL midrst_q: got %h want 0", q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", st); end

    act(11'd3);
    nop(4);
    rd(11'd9);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (valid !== 1'(k == 5)) begin errors++; $display("FAIL persist_valid[%0d]: got %b want %b", k, valid, k == 5); end
      if (k == 5) begin
        checks++;
        if (q !== 32'h12345678) begin errors++; $display("FAIL persist_q: got %h want 12345678", q); end
      end
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_trcd_violation();
    test_precharge_reopen();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_model.md
# dram_model

Cycle-accurate, synthesizable SDRAM device model that responds to the single-bank DRAM command interface driven by the system's DRAM wrapper. It decodes activate, precharge, read, and byte-masked write commands. It enforces row-to-column, CAS, and precharge timing, stores data in an internal word array, and returns read data with a one-cycle valid pulse. It sits in the testbench and top-level simulation harness as the far end of the DRAM pins.

## Interface
Parameters:
- ROW_BITS, 8: row address bits used from A[10:0] (1..11).
- COL_BITS, 8: column address bits used from A[9:0] (1..10).
- T_RCD, 5: cycles from an ACT edge to the first legal column command (1..15).
- T_CL, 5: cycles from a READ edge to the valid pulse (1..15).
- T_RP, 5: cycles from a PRE edge to the next legal ACT (1..15).

Ports:
- clk, input, 1: single clock. All sampling happens on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- DRAM_CSn, input, 1: chip select, active low. When 1, the cycle is a NOP.
- DRAM_RASn, input, 1: row strobe, active low.
- DRAM_CASn, input, 1: column strobe, active low.
- DRAM_WEn, input, 4: per-byte write enable, active low. Bit i controls D[8i+7:8i].
- DRAM_A, input, 11: row address on ACT, column address on READ/WRITE.
- DRAM_D, input, 32: write data.
- DRAM_Q, output, 32: read data.
- DRAM_valid, output, 1: one-cycle pulse that qualifies DRAM_Q.
- err, output, 1: sticky protocol-violation flag.

## Operation
Command decode is sampled each edge with DRAM_CSn=0:
- ACT: RASn=0, CASn=1, WEn=4'hf. Latch row = A[ROW_BITS-1:0].
- PRE: RASn=0, CASn=1, WEn≠4'hf.
- READ: RASn=1, CASn=0, WEn=4'hf. Column = A[COL_BITS-1:0].
- WRITE: RASn=1, CASn=0, WEn≠4'hf.
- RASn=1, CASn=1: NOP.
- RASn=0, CASn=0: illegal. Set err and ignore the command.

State machine:
- States are IDLE, ACTIVATING, ACTIVE, PRECHARGING. A 4-bit timer is loaded on entry to ACTIVATING and PRECHARGING.
- IDLE --ACT--> ACTIVATING. It holds for T_RCD cycles, then moves to ACTIVE.
- ACTIVE --PRE--> PRECHARGING. It holds for T_RP cycles, then moves to IDLE.
- PRE in IDLE is a legal no-op.

Array:
- Depth is 2^(ROW_BITS+COL_BITS) 32-bit words. Word index = {row, col}.
- WRITE updates only the bytes whose WEn bit is 0, at the sampling edge.
- A READ on the following edge returns the new data.

Read path:
- A READ captures the array word at its sampling edge into a T_CL-deep delay line of {valid, data}.
- Reads may be issued on consecutive edges. Each one produces its own pulse.
- Data is captured at command time, so a PRE or a later WRITE issued after the READ does not alter data already in flight.

Violations: set err and ignore the command, with no state, array, or pipeline change:
- READ or WRITE outside ACTIVE, including during ACTIVATING.
- ACT outside IDLE, including during PRECHARGING and ACT while ACTIVE.
- PRE during ACTIVATING.
- Illegal strobe combination.

err clears only on reset.

## Timing
Reset values (rst=0):
- DRAM_Q=0, DRAM_valid=0, err=0.
- State IDLE, timer 0, delay line cleared.
- Array contents are not reset and persist across reset.

Latencies:
- ACT at edge t0: the first legal column command is at edge t0+T_RCD.
- PRE at edge t1: the first legal ACT is at edge t1+T_RP.
- READ at edge t: DRAM_Q and DRAM_valid update at edge t+T_CL. DRAM_valid drops at edge t+T_CL+1 unless another read completes then.

Outputs:
- DRAM_Q holds its last delivered value between pulses.
- All outputs are registered. There is no combinational path from inputs to outputs.

Reset mid-operation:
- Reset asserted while reads are in flight discards them. No pulse is produced after reset release.
- After reset, the model is in IDLE and any open row is forgotten.

Boundaries:
- Column and row bits above COL_BITS/ROW_BITS are ignored; the address wraps within the array.
- With T_RCD=1, a column command is legal on the edge immediately after ACT.

## Test plan
- **Reset:** Drive rst=0 mid-run, then release. Require DRAM_Q=0, DRAM_valid=0, err=0, and no pulse afterwards.
- **Full write then read:**
  - ACT row 3, wait 5 cycles.
  - WRITE col 7 with WEn=4'h0, D=32'hDEADBEEF.
  - READ col 7 on the next edge.
  - Require DRAM_valid for exactly one cycle, 5 edges after the READ, with DRAM_Q=32'hDEADBEEF and err=0.
- **Byte mask:** On the same location, WRITE WEn=4'b1010, D=32'h11223344, then READ. Require DRAM_Q=32'hDE22BE44.
- **tRCD violation:** ACT row 4, then READ 2 cycles later. Require err=1, no valid pulse, and the state still reaching ACTIVE.
- **Precharge, reopen, and tRP:**
  - PRE, then ACT row 5 two cycles later. Require err=1.
  - ACT row 3 after 5 cycles, then READ col 7. Require 32'hDE22BE44, showing data persistence.
- **Back-to-back reads and mid-flight reset:**
  - READs on 3 consecutive edges. Require 3 consecutive valid cycles with the matching data.
  - Repeat, asserting rst 2 cycles after the first READ. Require no pulse and the array data intact on re-read.
